// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encodings and the
// divide-class operation codes used by the ALU decode.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_t;

    function automatic logic is_signed_op(input div_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/seq_divider_adder.sv
// Ripple-carry adder/subtractor: sum = a + (sub ? ~b : b) + sub.
// cout=1 on a subtraction means no borrow (a >= b).
module ripple_carry_adder_subtractor #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0]   carry;
    logic [N-1:0] b_eff;

    always_comb begin
        b_eff    = b ^ {N{sub}};
        carry    = '0;
        carry[0] = sub;
        sum      = '0;
        for (int i = 0; i < N; i++) begin
            sum[i]       = a[i] ^ b_eff[i] ^ carry[i];
            carry[i+1]   = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
        end
        cout = carry[N];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU), one trial subtraction per
// cycle, valid/ready handshakes on request and result sides.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | in_ready=1, waiting for a request
//   ST_CALC | one quotient bit per cycle, counter N-1 down to 0
//   ST_DONE | out_valid=1, result registers held until out_ready
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_signed,
    input  logic [N-1:0] in_dividend,
    input  logic [N-1:0] in_divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_quotient,
    output logic [N-1:0] out_remainder,
    output logic         out_dbz
);

    localparam int             CW       = $clog2(N);
    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [N-1:0]   ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]   MIN_NEG  = {1'b1, {(N-1){1'b0}}};

    function automatic logic [N-1:0] negate(input logic [N-1:0] x);
        return ~x + ONE;
    endfunction

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   pr_q, pr_d;
    logic [N-1:0]   sr_q, sr_d;
    logic [N-1:0]   dv_q, dv_d;
    logic           qneg_q, qneg_d;
    logic           rneg_q, rneg_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   rmd_q, rmd_d;
    logic           dbz_q, dbz_d;

    logic [N:0]     trial_a;
    logic [N:0]     trial_b;
    logic [N:0]     trial_sum;
    logic           trial_cout;
    logic           unused_trial_msb;
    logic [N-1:0]   pr_step;
    logic [N-1:0]   sr_step;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;

    // Shift the next dividend bit into the partial remainder, then try D.
    assign trial_a = {pr_q, sr_q[N-1]};
    assign trial_b = {1'b0, dv_q};

    ripple_carry_adder_subtractor #(.N(N + 1)) u_trial (
        .a    (trial_a),
        .b    (trial_b),
        .sub  (1'b1),
        .sum  (trial_sum),
        .cout (trial_cout)
    );

    // A successful trial never exceeds the divisor, so the top bit is always 0.
    assign unused_trial_msb = trial_sum[N];
    assign pr_step = trial_cout ? trial_sum[N-1:0] : trial_a[N-1:0];
    assign sr_step = {sr_q[N-2:0], trial_cout};

    assign a_mag = (in_signed && in_dividend[N-1]) ? negate(in_dividend) : in_dividend;
    assign b_mag = (in_signed && in_divisor[N-1])  ? negate(in_divisor)  : in_divisor;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        sr_d    = sr_q;
        dv_d    = dv_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dbz_d  = 1'b0;
                    qneg_d = in_signed & (in_dividend[N-1] ^ in_divisor[N-1]);
                    rneg_d = in_signed & in_dividend[N-1];
                    if (in_divisor == '0) begin
                        quot_d  = '1;
                        rmd_d   = in_dividend;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (in_signed && in_dividend == MIN_NEG && in_divisor == '1) begin
                        quot_d  = in_dividend;
                        rmd_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        pr_d    = '0;
                        sr_d    = a_mag;
                        dv_d    = b_mag;
                        cnt_d   = CNT_LAST;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                pr_d  = pr_step;
                sr_d  = sr_step;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    quot_d  = qneg_q ? negate(sr_step) : sr_step;
                    rmd_d   = rneg_q ? negate(pr_step) : pr_step;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            sr_q    <= '0;
            dv_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quot_q  <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            sr_q    <= sr_d;
            dv_q    <= dv_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_DONE);
    assign out_quotient  = quot_q;
    assign out_remainder = rmd_q;
    assign out_dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (N=32): the driver pushes hand-computed
// results at accept, a negedge monitor pops and compares each presented result.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_signed = 1'b0;
    logic [31:0] in_dividend = '0;
    logic [31:0] in_divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_quotient;
    logic [31:0] out_remainder;
    logic        out_dbz;

    seq_divider #(.N(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_signed     (in_signed),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_dbz       (out_dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   cur_loaded = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc++;

    // Monitor: pops on the first cycle a result is shown, compares every held cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!cur_loaded) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got q=%h r=%h with nothing expected",
                             out_quotient, out_remainder);
                end else begin
                    cur = sb.pop_front();
                    cur_loaded = 1'b1;
                    if (cyc - cur.acc != cur.lat) begin
                        errors++;
                        $display("FAIL %s latency: got %0d required %0d",
                                 cur.name, cyc - cur.acc, cur.lat);
                    end
                end
            end
            if (cur_loaded) begin
                checks++;
                if (out_quotient !== cur.q || out_remainder !== cur.r || out_dbz !== cur.dbz) begin
                    errors++;
                    $display("FAIL %s result: got q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
                             cur.name, out_quotient, out_remainder, out_dbz,
                             cur.q, cur.r, cur.dbz);
                end
                if (out_ready) cur_loaded = 1'b0;
            end
        end
    end

    task automatic do_op(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz, input int elat);
        exp_t e;
        bit   ok;
        @(posedge clk);
        #1;
        in_valid    = 1'b1;
        in_signed   = sgn;
        in_dividend = a;
        in_divisor  = b;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.name = name; e.q = eq; e.r = er; e.dbz = edbz; e.lat = elat; e.acc = cyc;
                sb.push_back(e);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s accept_timeout: in_ready=%b required 1", name, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !cur_loaded) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s drain_timeout: %0d results outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic expect_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    task automatic expect_word(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        expect_bit("reset_out_valid", out_valid, 1'b0);
        expect_word("reset_quotient", out_quotient, 32'h0);
        expect_word("reset_remainder", out_remainder, 32'h0);
        expect_bit("reset_dbz", out_dbz, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        expect_bit("idle_in_ready", in_ready, 1'b1);

        do_op("u_100_7",     1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 33);
        do_op("s_m7_2",      1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 33);
        do_op("s_7_m2",      1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0, 33);
        do_op("s_m100_m7",   1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0, 33);
        do_op("s_dbz",       1'b1, 32'h12345678,  32'h0,         32'hFFFFFFFF,  32'h12345678,  1'b1, 1);
        do_op("u_dbz",       1'b0, 32'h12345678,  32'h0,         32'hFFFFFFFF,  32'h12345678,  1'b1, 1);
        do_op("s_overflow",  1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h0,         1'b0, 1);
        do_op("u_ovf_ops",   1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h0,         32'h80000000,  1'b0, 33);
        do_op("s_minneg_1",  1'b1, 32'h80000000,  32'd1,         32'h80000000,  32'h0,         1'b0, 33);
        do_op("u_0_5",       1'b0, 32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 33);
        wait_idle("directed");

        // Backpressure: hold the result for 10 cycles while a new request waits.
        @(posedge clk);
        #1 out_ready = 1'b0;
        do_op("bp_first",    1'b0, 32'd1000,      32'd10,        32'd100,       32'd0,         1'b0, 33);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL bp_first out_valid_timeout: got 0 required 1");
        end
        fork
            do_op("bp_second", 1'b0, 32'd5,       32'd9,         32'd0,         32'd5,         1'b0, 33);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    expect_bit("bp_in_ready_low", in_ready, 1'b0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                expect_bit("bp_idle_in_ready", in_ready, 1'b1);
                expect_bit("bp_idle_out_valid", out_valid, 1'b0);
            end
        join
        wait_idle("backpressure");

        // Reset during CALC abandons the operation.
        do_op("aborted",     1'b0, 32'hFFFFFFFF,  32'd3,         32'h55555555,  32'h0,         1'b0, 33);
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        expect_bit("abort_out_valid", out_valid, 1'b0);
        expect_word("abort_quotient", out_quotient, 32'h0);
        expect_word("abort_remainder", out_remainder, 32'h0);
        expect_bit("abort_dbz", out_dbz, 1'b0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        expect_bit("post_reset_in_ready", in_ready, 1'b1);
        do_op("u_max_1",     1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'h0,         1'b0, 33);
        wait_idle("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
